// File: rtl/wb_queue.sv
// wb_queue: write-back stage behind execute. Packets {data, addr, opcode}
// are queued in an in-order FIFO and retired one at a time either as a
// single-cycle GPR write or as a RAM write that waits for a grant, with a
// bounded wait that drops the write and raises a sticky error flag.
module wb_queue #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W+ADDR_W+3:0] DAO,
  output logic                     GPR_wr,
  output logic [DATA_W-1:0]        data_GPRout,
  output logic [ADDR_W-1:0]        addr_GPRout,
  output logic                     ram_wr,
  input  logic                     ram_garant_wr,
  output logic [DATA_W-1:0]        data_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PKT_W = DATA_W + ADDR_W + 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Opcode encodings shared with the execute stage
  localparam logic [3:0] OP_MOV_SA  = 4'h1;
  localparam logic [3:0] OP_MOV_SR  = 4'h2;
  localparam logic [3:0] OP_MOV_BIO = 4'h3;
  localparam logic [3:0] OP_INC_BIO = 4'h4;
  localparam logic [3:0] OP_INC_SR  = 4'h5;
  localparam logic [3:0] OP_POP_R   = 4'h6;
  localparam logic [3:0] OP_XOR_SR  = 4'h7;
  localparam logic [3:0] OP_XOR_BIO = 4'h8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RAM} state_t;

  state_t            state;
  logic [PKT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  timer;
  logic [DATA_W-1:0] cur_data;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        cur_op;
  logic [PKT_W-1:0]  head;
  logic              do_push;
  logic              do_pop;

  function automatic logic is_ram(input logic [3:0] op);
    return (op == OP_MOV_SR) || (op == OP_MOV_BIO) || (op == OP_INC_BIO) ||
           (op == OP_XOR_SR) || (op == OP_XOR_BIO);
  endfunction

  function automatic logic is_gpr(input logic [3:0] op);
    return (op == OP_MOV_SA) || (op == OP_INC_SR) || (op == OP_POP_R);
  endfunction

  // No pass-through: a full queue refuses input even if it pops this cycle
  assign in_ready = (level < LVL_W'(DEPTH));
  assign do_push  = in_valid & in_ready;
  assign do_pop   = (state == IDLE) && (level != '0);
  assign busy     = (level != '0) || (state != IDLE);
  assign head     = mem[rptr];

  // FIFO storage, written at the write pointer on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= DAO;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Retire FSM: pop in IDLE, issue the strobe, then wait for RAM grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      GPR_wr      <= 1'b0;
      ram_wr      <= 1'b0;
      timeout_err <= 1'b0;
      data_GPRout <= '0;
      addr_GPRout <= '0;
      data_out    <= '0;
      addr_out    <= '0;
      timer       <= '0;
      cur_data    <= '0;
      cur_addr    <= '0;
      cur_op      <= '0;
    end else begin
      GPR_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (do_pop) begin
            cur_data <= head[PKT_W-1 -: DATA_W];
            cur_addr <= head[ADDR_W+3 -: ADDR_W];
            cur_op   <= head[3:0];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_gpr(cur_op)) begin
            GPR_wr      <= 1'b1;
            data_GPRout <= cur_data;
            addr_GPRout <= cur_addr;
            state       <= IDLE;
          end else if (is_ram(cur_op)) begin
            ram_wr   <= 1'b1;
            data_out <= cur_data;
            addr_out <= cur_addr;
            timer    <= '0;
            state    <= WAIT_RAM;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RAM: begin
          if (ram_garant_wr) begin
            ram_wr <= 1'b0;
            state  <= IDLE;
          end else if (timer == CNT_W'(TIMEOUT - 1)) begin
            ram_wr      <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed bench for wb_queue. Inputs change 1 time unit after
// each rising edge and outputs are sampled at the same point.
module tb_wb_queue;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int TIMEOUT = 15;

  localparam logic [3:0] OP_MOV_SA  = 4'h1;
  localparam logic [3:0] OP_MOV_SR  = 4'h2;
  localparam logic [3:0] OP_MOV_BIO = 4'h3;
  localparam logic [3:0] OP_INC_BIO = 4'h4;
  localparam logic [3:0] OP_INC_SR  = 4'h5;
  localparam logic [3:0] OP_POP_R   = 4'h6;
  localparam logic [3:0] OP_XOR_BIO = 4'h8;
  localparam logic [3:0] OP_ILLEGAL = 4'hF;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W+ADDR_W+3:0] DAO;
  logic                     GPR_wr;
  logic [DATA_W-1:0]        data_GPRout;
  logic [ADDR_W-1:0]        addr_GPRout;
  logic                     ram_wr;
  logic                     ram_garant_wr;
  logic [DATA_W-1:0]        data_out;
  logic [ADDR_W-1:0]        addr_out;
  logic [$clog2(DEPTH):0]   level;
  logic                     busy;
  logic                     timeout_err;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] gpr_log[$];

  wb_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .DAO(DAO), .GPR_wr(GPR_wr), .data_GPRout(data_GPRout),
    .addr_GPRout(addr_GPRout), .ram_wr(ram_wr), .ram_garant_wr(ram_garant_wr),
    .data_out(data_out), .addr_out(addr_out), .level(level), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Record every GPR write strobe mid-cycle so retire order can be checked later
  always @(negedge clk) begin
    if (!reset && GPR_wr) gpr_log.push_back({addr_GPRout, data_GPRout});
  end

  function automatic logic [DATA_W+ADDR_W+3:0] pack(input logic [DATA_W-1:0] d,
                                                    input logic [ADDR_W-1:0] a,
                                                    input logic [3:0] op);
    return {d, a, op};
  endfunction

  task automatic stepCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DATA_W+ADDR_W+3:0] pkt);
    in_valid = valid;
    DAO      = pkt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One GPR retirement from IDLE: pop edge without strobe, then the strobe edge
  task automatic retireGpr(input string tag, input logic [DATA_W-1:0] d,
                           input logic [ADDR_W-1:0] a);
    stepCycles(1);
    checkOutput({tag, "_pop_nostrobe"}, 32'(GPR_wr), 32'd0);
    stepCycles(1);
    checkOutput({tag, "_strobe"}, 32'(GPR_wr), 32'd1);
    checkOutput({tag, "_data"}, 32'(data_GPRout), 32'(d));
    checkOutput({tag, "_addr"}, 32'(addr_GPRout), 32'(a));
  endtask

  initial begin
    int wait_cnt;
    logic [ADDR_W+DATA_W-1:0] entry;

    // Reset state
    reset = 1'b1;
    ram_garant_wr = 1'b0;
    applyStimulus(1'b0, '0);
    stepCycles(2);
    reset = 1'b0;
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gpr_wr", 32'(GPR_wr), 32'd0);
    checkOutput("rst_ram_wr", 32'(ram_wr), 32'd0);
    checkOutput("rst_terr", 32'(timeout_err), 32'd0);
    checkOutput("rst_data_gpr", 32'(data_GPRout), 32'd0);
    checkOutput("rst_addr_out", 32'(addr_out), 32'd0);

    // Single GPR packet: strobe in the cycle after push edge + 2
    applyStimulus(1'b1, pack(14'h155, 12'h003, OP_MOV_SA));
    stepCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("t1_level_push", 32'(level), 32'd1);
    checkOutput("t1_no_strobe_e0", 32'(GPR_wr), 32'd0);
    stepCycles(1);
    checkOutput("t1_level_pop", 32'(level), 32'd0);
    checkOutput("t1_no_strobe_e1", 32'(GPR_wr), 32'd0);
    checkOutput("t1_busy_issue", 32'(busy), 32'd1);
    stepCycles(1);
    checkOutput("t1_strobe", 32'(GPR_wr), 32'd1);
    checkOutput("t1_data", 32'(data_GPRout), 32'h155);
    checkOutput("t1_addr", 32'(addr_GPRout), 32'h003);
    stepCycles(1);
    checkOutput("t1_strobe_off", 32'(GPR_wr), 32'd0);
    checkOutput("t1_busy_off", 32'(busy), 32'd0);
    checkOutput("t1_data_hold", 32'(data_GPRout), 32'h155);

    // RAM packet granted after 3 low cycles: ram_wr high for 4 cycles
    applyStimulus(1'b1, pack(14'h2AA, 12'h7F0, OP_XOR_BIO));
    stepCycles(1);
    applyStimulus(1'b0, '0);
    stepCycles(2);
    checkOutput("t2_ram_wr_rise", 32'(ram_wr), 32'd1);
    checkOutput("t2_data", 32'(data_out), 32'h2AA);
    checkOutput("t2_addr", 32'(addr_out), 32'h7F0);
    for (int i = 0; i < 3; i++) begin
      stepCycles(1);
      checkOutput($sformatf("t2_ram_wr_hold%0d", i), 32'(ram_wr), 32'd1);
      checkOutput($sformatf("t2_addr_hold%0d", i), 32'(addr_out), 32'h7F0);
    end
    ram_garant_wr = 1'b1;
    stepCycles(1);
    ram_garant_wr = 1'b0;
    checkOutput("t2_ram_wr_fall", 32'(ram_wr), 32'd0);
    checkOutput("t2_terr", 32'(timeout_err), 32'd0);
    checkOutput("t2_data_hold", 32'(data_out), 32'h2AA);
    checkOutput("t2_busy", 32'(busy), 32'd0);

    // Back-pressure: a stalled RAM write (P0) plus four GPR packets fill
    // the queue, so the fifth GPR packet (P5) is held off until a pop
    applyStimulus(1'b1, pack(14'h011, 12'h101, OP_MOV_SR));
    stepCycles(1);
    checkOutput("t3_level_e1", 32'(level), 32'd1);
    applyStimulus(1'b1, pack(14'h021, 12'h201, OP_INC_SR));
    stepCycles(1);
    checkOutput("t3_level_e2", 32'(level), 32'd1);
    applyStimulus(1'b1, pack(14'h022, 12'h202, OP_INC_SR));
    stepCycles(1);
    checkOutput("t3_level_e3", 32'(level), 32'd2);
    checkOutput("t3_ram_wr", 32'(ram_wr), 32'd1);
    applyStimulus(1'b1, pack(14'h023, 12'h203, OP_INC_SR));
    stepCycles(1);
    checkOutput("t3_level_e4", 32'(level), 32'd3);
    applyStimulus(1'b1, pack(14'h024, 12'h204, OP_INC_SR));
    stepCycles(1);
    checkOutput("t3_level_full", 32'(level), 32'd4);
    checkOutput("t3_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, pack(14'h025, 12'h205, OP_INC_SR));
    stepCycles(1);
    checkOutput("t3_held_level", 32'(level), 32'd4);
    checkOutput("t3_held_ready", 32'(in_ready), 32'd0);
    ram_garant_wr = 1'b1;
    stepCycles(1);
    ram_garant_wr = 1'b0;
    checkOutput("t3_grant_fall", 32'(ram_wr), 32'd0);
    checkOutput("t3_grant_level", 32'(level), 32'd4);
    checkOutput("t3_addr_out", 32'(addr_out), 32'h101);
    stepCycles(1);
    checkOutput("t3_pop_level", 32'(level), 32'd3);
    checkOutput("t3_ready_high", 32'(in_ready), 32'd1);
    stepCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("t3_accept_level", 32'(level), 32'd4);
    checkOutput("t3_p1_strobe", 32'(GPR_wr), 32'd1);
    checkOutput("t3_p1_data", 32'(data_GPRout), 32'h021);
    checkOutput("t3_p1_addr", 32'(addr_GPRout), 32'h201);
    retireGpr("t3_p2", 14'h022, 12'h202);
    retireGpr("t3_p3", 14'h023, 12'h203);
    retireGpr("t3_p4", 14'h024, 12'h204);
    retireGpr("t3_p5", 14'h025, 12'h205);
    stepCycles(1);
    checkOutput("t3_drained", 32'(busy), 32'd0);

    // Timeout: RAM write never granted, then a queued GPR packet retires
    applyStimulus(1'b1, pack(14'h0AB, 12'h3CD, OP_MOV_BIO));
    stepCycles(1);
    applyStimulus(1'b1, pack(14'h0CD, 12'h0EF, OP_POP_R));
    stepCycles(1);
    applyStimulus(1'b0, '0);
    stepCycles(1);
    checkOutput("t4_ram_wr_rise", 32'(ram_wr), 32'd1);
    for (int i = 1; i < TIMEOUT; i++) begin
      stepCycles(1);
      checkOutput($sformatf("t4_wait%0d_ram_wr", i), 32'(ram_wr), 32'd1);
      checkOutput($sformatf("t4_wait%0d_terr", i), 32'(timeout_err), 32'd0);
    end
    stepCycles(1);
    checkOutput("t4_drop_ram_wr", 32'(ram_wr), 32'd0);
    checkOutput("t4_drop_terr", 32'(timeout_err), 32'd1);
    retireGpr("t4_next", 14'h0CD, 12'h0EF);
    stepCycles(1);
    checkOutput("t4_terr_sticky", 32'(timeout_err), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);

    // Mixed stream RAM, GPR, illegal, GPR with grant held high
    ram_garant_wr = 1'b1;
    applyStimulus(1'b1, pack(14'h101, 12'h111, OP_INC_BIO));
    stepCycles(1);
    applyStimulus(1'b1, pack(14'h202, 12'h222, OP_MOV_SA));
    stepCycles(1);
    applyStimulus(1'b1, pack(14'h303, 12'h333, OP_ILLEGAL));
    stepCycles(1);
    checkOutput("t5_ram_wr", 32'(ram_wr), 32'd1);
    checkOutput("t5_ram_addr", 32'(addr_out), 32'h111);
    applyStimulus(1'b1, pack(14'h304, 12'h444, OP_INC_SR));
    stepCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("t5_ram_done", 32'(ram_wr), 32'd0);
    checkOutput("t5_level", 32'(level), 32'd3);
    retireGpr("t5_b", 14'h202, 12'h222);
    stepCycles(1);
    checkOutput("t5_c_pop", 32'(GPR_wr), 32'd0);
    stepCycles(1);
    checkOutput("t5_c_no_gpr", 32'(GPR_wr), 32'd0);
    checkOutput("t5_c_no_ram", 32'(ram_wr), 32'd0);
    retireGpr("t5_d", 14'h304, 12'h444);
    ram_garant_wr = 1'b0;
    stepCycles(1);
    checkOutput("t5_busy", 32'(busy), 32'd0);

    // Wrap-around: stream 10 GPR packets through the 4-entry queue
    gpr_log.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, pack(14'h050 + 14'(i), 12'h500 + 12'(i), OP_MOV_SA));
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
        stepCycles(1);
        wait_cnt++;
      end
      checkOutput($sformatf("t6_accept%0d", i), 32'(wait_cnt < 50), 32'd1);
      stepCycles(1);
    end
    applyStimulus(1'b0, '0);
    stepCycles(30);
    checkOutput("t6_count", 32'(gpr_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      entry = (i < gpr_log.size()) ? gpr_log[i] : '0;
      checkOutput($sformatf("t6_order%0d", i), 32'(entry),
                  32'({12'h500 + 12'(i), 14'h050 + 14'(i)}));
    end
    checkOutput("t6_level", 32'(level), 32'd0);

    // Reset while waiting for RAM with three packets queued
    applyStimulus(1'b1, pack(14'h0F0, 12'h0F1, OP_MOV_SR));
    stepCycles(1);
    applyStimulus(1'b1, pack(14'h0F2, 12'h0F3, OP_MOV_SA));
    stepCycles(1);
    applyStimulus(1'b1, pack(14'h0F4, 12'h0F5, OP_MOV_SA));
    stepCycles(1);
    applyStimulus(1'b1, pack(14'h0F6, 12'h0F7, OP_MOV_SA));
    stepCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("t7_pre_ram_wr", 32'(ram_wr), 32'd1);
    checkOutput("t7_pre_level", 32'(level), 32'd3);
    checkOutput("t7_pre_terr", 32'(timeout_err), 32'd1);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("t7_ram_wr", 32'(ram_wr), 32'd0);
    checkOutput("t7_level", 32'(level), 32'd0);
    checkOutput("t7_ready", 32'(in_ready), 32'd1);
    checkOutput("t7_terr", 32'(timeout_err), 32'd0);
    checkOutput("t7_data_out", 32'(data_out), 32'd0);
    checkOutput("t7_addr_out", 32'(addr_out), 32'd0);
    checkOutput("t7_data_gpr", 32'(data_GPRout), 32'd0);
    checkOutput("t7_addr_gpr", 32'(addr_GPRout), 32'd0);
    checkOutput("t7_busy", 32'(busy), 32'd0);
    stepCycles(3);
    checkOutput("t7_idle_gpr", 32'(GPR_wr), 32'd0);
    checkOutput("t7_idle_ram", 32'(ram_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
